// File: rtl/lscnt_up_counter.sv
// Loadable synchronous up counter with carry chain, registered complement and sticky overflow.
// Optional auto-reload on wrap is enabled by defining LSCNT_UP_AUTORELOAD_EN.
module lscnt_up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic             EN,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             CO,
  output logic             OVF
);

`ifdef LSCNT_UP_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] ql_r;
  logic             ovf_r;
  logic [WIDTH-1:0] rldv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrap_val;

  // The extra MSB of the increment flags the wrap and is never stored.
  assign sum      = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
  assign wrap_val = AUTORELOAD ? rldv : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r   <= '0;
      ql_r  <= '1;
      ovf_r <= 1'b0;
      rldv  <= '0;
    end else if (LD) begin
      q_r   <= D;
      ql_r  <= ~D;
      ovf_r <= 1'b0;
      rldv  <= D;
    end else if (EN && CI) begin
      if (sum[WIDTH]) begin
        q_r   <= wrap_val;
        ql_r  <= ~wrap_val;
        ovf_r <= 1'b1;
      end else begin
        q_r  <= sum[WIDTH-1:0];
        ql_r <= ~sum[WIDTH-1:0];
      end
    end
  end

  // Carry out ignores LD so that chained stages advance on the same edge.
  assign CO  = EN & CI & (&q_r);
  assign Q   = q_r;
  assign QL  = ql_r;
  assign OVF = ovf_r;

endmodule

// File: tb/tb_lscnt_up_counter.sv
// Self-checking bench for lscnt_up_counter: directed cases, random stimulus and a 2x4-bit cascade,
// all compared against an arithmetic reference model.
module tb_lscnt_up_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d   = '0;
  logic       ld  = 1'b0;
  logic       en  = 1'b0;
  logic       ci  = 1'b0;
  logic [7:0] q;
  logic [7:0] ql;
  logic       co;
  logic       ovf;

  // cascade pair: two 4-bit stages, upper CI fed from lower CO
  logic       c_rst = 1'b0;
  logic [7:0] c_d   = '0;
  logic       c_ld  = 1'b0;
  logic       c_en  = 1'b0;
  logic       c_ci  = 1'b0;
  logic [3:0] lo_q, lo_ql, hi_q, hi_ql;
  logic       lo_co, hi_co, lo_ovf, hi_ovf;

  int checks = 0;
  int errors = 0;

  int m_q = 0;
  bit m_ovf = 1'b0;
  int m_rldv = 0;

  int m_lo_q = 0, m_lo_rldv = 0, m_hi_q = 0, m_hi_rldv = 0;
  bit m_lo_ovf = 1'b0, m_hi_ovf = 1'b0;

`ifdef LSCNT_UP_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  lscnt_up_counter #(.WIDTH(8)) dut (
    .CLK(clk), .RST(rst), .D(d), .LD(ld), .EN(en), .CI(ci),
    .Q(q), .QL(ql), .CO(co), .OVF(ovf)
  );

  lscnt_up_counter #(.WIDTH(4)) lo_stage (
    .CLK(clk), .RST(c_rst), .D(c_d[3:0]), .LD(c_ld), .EN(c_en), .CI(c_ci),
    .Q(lo_q), .QL(lo_ql), .CO(lo_co), .OVF(lo_ovf)
  );

  lscnt_up_counter #(.WIDTH(4)) hi_stage (
    .CLK(clk), .RST(c_rst), .D(c_d[7:4]), .LD(c_ld), .EN(c_en), .CI(lo_co),
    .Q(hi_q), .QL(hi_ql), .CO(hi_co), .OVF(hi_ovf)
  );

  always #5 clk = ~clk;

  // Reference: value range 0..2^w-1, RST > LD > count > hold, wrap to 0 or reload value.
  task automatic model_cnt(input int w, input bit r, input bit l, input int dv, input bit e,
                           input bit c, inout int mq, inout bit mo, inout int mr);
    int top;
    top = (1 << w) - 1;
    if (r) begin
      mq = 0; mo = 1'b0; mr = 0;
    end else if (l) begin
      mq = dv & top; mo = 1'b0; mr = dv & top;
    end else if (e && c) begin
      if (mq == top) begin
        mq = AUTORELOAD ? mr : 0;
        mo = 1'b1;
      end else begin
        mq = mq + 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit l, input int dv, input bit e, input bit c);
    @(negedge clk);
    rst = r; ld = l; d = dv[7:0]; en = e; ci = c;
    @(posedge clk);
    model_cnt(8, r, l, dv, e, c, m_q, m_ovf, m_rldv);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit exp_co;
    exp_co = en && ci && (m_q == 255);
    checks++;
    assert (q === m_q[7:0]) else begin
      errors++;
      $error("[TB] FAIL %s.Q observed=%h expected=%h", tag, q, m_q[7:0]);
    end
    checks++;
    assert (ql === ~m_q[7:0]) else begin
      errors++;
      $error("[TB] FAIL %s.QL observed=%h expected=%h", tag, ql, ~m_q[7:0]);
    end
    checks++;
    assert (co === exp_co) else begin
      errors++;
      $error("[TB] FAIL %s.CO observed=%b expected=%b", tag, co, exp_co);
    end
    checks++;
    assert (ovf === m_ovf) else begin
      errors++;
      $error("[TB] FAIL %s.OVF observed=%b expected=%b", tag, ovf, m_ovf);
    end
  endtask

  task automatic cascadeStep(input bit r, input bit l, input int dv, input bit e, input bit c,
                             input string tag);
    bit lo_carry;
    int combined;
    bit exp_co;
    @(negedge clk);
    c_rst = r; c_ld = l; c_d = dv[7:0]; c_en = e; c_ci = c;
    @(posedge clk);
    lo_carry = e && c && (m_lo_q == 15);
    model_cnt(4, r, l, dv & 15, e, c, m_lo_q, m_lo_ovf, m_lo_rldv);
    model_cnt(4, r, l, (dv >> 4) & 15, e, lo_carry, m_hi_q, m_hi_ovf, m_hi_rldv);
    #1;
    combined = m_hi_q * 16 + m_lo_q;
    exp_co   = c_en && c_ci && (combined == 255);
    checks++;
    assert ({hi_q, lo_q} === combined[7:0]) else begin
      errors++;
      $error("[TB] FAIL %s.Q observed=%h expected=%h", tag, {hi_q, lo_q}, combined[7:0]);
    end
    checks++;
    assert ({hi_ql, lo_ql} === ~combined[7:0]) else begin
      errors++;
      $error("[TB] FAIL %s.QL observed=%h expected=%h", tag, {hi_ql, lo_ql}, ~combined[7:0]);
    end
    checks++;
    assert (hi_co === exp_co) else begin
      errors++;
      $error("[TB] FAIL %s.CO observed=%b expected=%b", tag, hi_co, exp_co);
    end
  endtask

  initial begin
    int dv;
    $display("[TB] start, autoreload=%0b", AUTORELOAD);

    applyStimulus(1, 1, 8'h55, 1, 1);
    applyStimulus(1, 1, 8'h55, 0, 0);
    checkOutput("reset");

    applyStimulus(0, 1, 8'hFC, 0, 0);
    checkOutput("load_fc");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("count_up");
    end

    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wrap");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("ovf_sticky");
    end
    applyStimulus(0, 1, 8'h20, 0, 0);
    checkOutput("ovf_clear");

    applyStimulus(0, 1, 8'hFD, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("reload_seq");
    end

    applyStimulus(0, 1, 8'hFF, 0, 0);
    checkOutput("load_ff");
    applyStimulus(0, 1, 8'h10, 1, 1);
    checkOutput("load_beats_wrap");
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("hold_ci0");
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hold_en0");

    applyStimulus(0, 1, 8'h42, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("reset_mid_count");

    for (int i = 0; i < 400; i++) begin
      dv = ($urandom_range(0, 1) == 1) ? (8'hF8 | $urandom_range(0, 7)) : $urandom_range(0, 255);
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, dv,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      checkOutput("random");
    end

    cascadeStep(1, 0, 0, 0, 0, "casc_reset");
    cascadeStep(0, 1, 8'h0F, 0, 0, "casc_load");
    cascadeStep(0, 0, 0, 1, 1, "casc_count");
    cascadeStep(0, 1, 8'hFD, 1, 1, "casc_load_fd");
    cascadeStep(0, 0, 0, 1, 1, "casc_fe");
    cascadeStep(0, 0, 0, 1, 1, "casc_ff");
    cascadeStep(0, 0, 0, 0, 1, "casc_ff_en0");
    cascadeStep(0, 0, 0, 1, 0, "casc_ff_ci0");
    cascadeStep(0, 0, 0, 1, 1, "casc_wrap");
    for (int i = 0; i < 100; i++) begin
      cascadeStep($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, "casc_random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
